// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Turns the raw EHXPLLL lock flag into a lock-qualified, registered,
// active-high system reset for the 125 MHz domain. It also keeps a
// saturating count of lock losses seen while running, and drives the
// active-low board LED as a lock/health indicator.
//
// The reset is released only after the synchronized lock flag has stayed
// high for STABLE_CYCLES consecutive cycles plus HOLD_CYCLES more. Any drop
// of the lock flag during qualification restarts the whole sequence.
module pll_reset_sequencer #(
  parameter int STABLE_CYCLES = 125000,
  parameter int HOLD_CYCLES   = 16,
  parameter int BLINK_BIT     = 26
) (
  input  logic       clock_125mhz,
  input  logic       reset,
  input  logic       pll_locked,
  output logic       sys_reset,
  output logic       ready,
  output logic [7:0] lock_lost_count,
  output logic       led
);

  // The phase counter must reach the larger of the two qualification
  // lengths minus one. The width is kept at least one bit so that
  // degenerate settings such as 1/1 still elaborate.
  localparam int MAX_CYCLES = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam int BLINK_W    = BLINK_BIT + 1;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [BLINK_W-1:0] BLINK_ONE = BLINK_W'(1);

  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_STABILIZE = 2'd1;
  localparam logic [1:0] ST_HOLD      = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  // Lock-loss counter increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    if (value == 8'hFF) begin
      return value;
    end
    return value + 8'd1;
  endfunction

  // LED drive for a given state: off while waiting for lock, solid on while
  // qualifying, and the blink bit while running.
  function automatic logic led_for_state(input logic [1:0] st, input logic blink_bit);
    case (st)
      ST_WAIT_LOCK: return 1'b1;
      ST_STABILIZE: return 1'b0;
      ST_HOLD:      return 1'b0;
      default:      return blink_bit;
    endcase
  endfunction

  logic               lock_meta;
  logic               locked_s;
  logic [1:0]         state;
  logic [1:0]         next_state;
  logic [CNT_W-1:0]   phase_cnt;
  logic [CNT_W-1:0]   phase_cnt_next;
  logic [BLINK_W-1:0] blink_cnt;
  logic [BLINK_W-1:0] blink_cnt_next;
  logic [7:0]         lost_next;
  logic               led_next;

  // Two-flop synchronizer bringing the asynchronous PLL lock flag into the
  // 125 MHz domain; nothing downstream looks at pll_locked directly.
  always_ff @(posedge clock_125mhz) begin
    if (reset) begin
      lock_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      locked_s  <= lock_meta;
    end
  end

  // Next-state, phase-count and lock-loss decisions for the qualification FSM.
  always_comb begin
    next_state     = state;
    phase_cnt_next = phase_cnt;
    lost_next      = lock_lost_count;

    case (state)
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          next_state = ST_STABILIZE;
        end
      end

      ST_STABILIZE: begin
        if (!locked_s) begin
          next_state = ST_WAIT_LOCK;
        end else if (phase_cnt == STABLE_LAST) begin
          next_state = ST_HOLD;
        end else begin
          phase_cnt_next = phase_cnt + CNT_ONE;
        end
      end

      ST_HOLD: begin
        if (!locked_s) begin
          next_state = ST_WAIT_LOCK;
        end else if (phase_cnt == HOLD_LAST) begin
          next_state = ST_RUN;
        end else begin
          phase_cnt_next = phase_cnt + CNT_ONE;
        end
      end

      default: begin
        if (!locked_s) begin
          next_state = ST_WAIT_LOCK;
          lost_next  = sat_inc8(lock_lost_count);
        end
      end
    endcase

    // Every state change starts the next phase from zero, so partial
    // counts from an interrupted qualification are discarded.
    if (next_state != state) begin
      phase_cnt_next = '0;
    end
  end

  // Blink counter restarts on entry to RUN and free-runs while in RUN.
  // The LED is derived from the post-edge state and counter, so it lines
  // up with the registered sys_reset/ready outputs.
  always_comb begin
    blink_cnt_next = '0;
    if ((state == ST_RUN) && (next_state == ST_RUN)) begin
      blink_cnt_next = blink_cnt + BLINK_ONE;
    end
    led_next = led_for_state(next_state, blink_cnt_next[BLINK_BIT]);
  end

  // State, counters and all outputs advance together on the same edge.
  always_ff @(posedge clock_125mhz) begin
    if (reset) begin
      state           <= ST_WAIT_LOCK;
      phase_cnt       <= '0;
      blink_cnt       <= '0;
      sys_reset       <= 1'b1;
      ready           <= 1'b0;
      led             <= 1'b1;
      lock_lost_count <= 8'd0;
    end else begin
      state           <= next_state;
      phase_cnt       <= phase_cnt_next;
      blink_cnt       <= blink_cnt_next;
      sys_reset       <= (next_state != ST_RUN);
      ready           <= (next_state == ST_RUN);
      led             <= led_next;
      lock_lost_count <= lost_next;
    end
  end

endmodule
